// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - fixed-frequency PWM with debounced up/down duty buttons
// Each button runs sync -> debounce -> rising-edge pulse; duty changes land on period boundaries.

module pwm_btn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  localparam int DBW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic           s_meta;
  logic           s;
  logic           db;
  logic           db_q;
  logic [DBW-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      db     <= 1'b0;
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else begin
      s_meta <= btn;
      s      <= s_meta;
      db_q   <= db;
      // The edge that sees the Nth consecutive mismatch also commits the new level.
      if (s == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        db     <= s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign pulse = db & ~db_q;
endmodule

module pwm_gen #(
  parameter int PERIOD          = 10,
  parameter int DUTY_INIT       = 5,
  parameter int DUTY_STEP       = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic increase_duty,
  input  logic decrease_duty,
  output logic PWM_OUT
);
  localparam int CW = $clog2(PERIOD);
  localparam int DW = $clog2(PERIOD + 1);
  localparam logic [DW:0] STEP_W   = (DW + 1)'(DUTY_STEP);
  localparam logic [DW:0] PERIOD_W = (DW + 1)'(PERIOD);

  logic [CW-1:0] cnt;
  logic [DW-1:0] duty_req;
  logic [DW-1:0] duty_act;
  logic          inc_p;
  logic          dec_p;
  logic [DW:0]   duty_ext;
  logic [DW:0]   duty_up;
  logic [DW:0]   duty_dn;

  pwm_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (increase_duty),
    .pulse (inc_p)
  );

  pwm_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk   (clk),
    .reset (reset),
    .btn   (decrease_duty),
    .pulse (dec_p)
  );

  // One extra bit so saturation is detected before any wrap.
  always_comb begin
    duty_ext = {1'b0, duty_req};
    duty_up  = duty_ext + STEP_W;
    if (duty_up > PERIOD_W) duty_up = PERIOD_W;
    duty_dn  = (duty_ext < STEP_W) ? '0 : (duty_ext - STEP_W);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      duty_req <= DW'(DUTY_INIT);
      duty_act <= DW'(DUTY_INIT);
      PWM_OUT  <= 1'b0;
    end else begin
      if (cnt == CW'(PERIOD - 1)) begin
        cnt      <= '0;
        duty_act <= duty_req;
      end else begin
        cnt <= cnt + 1'b1;
      end
      PWM_OUT <= (DW'(cnt) < duty_act);
      if (inc_p && !dec_p)      duty_req <= duty_up[DW-1:0];
      else if (dec_p && !inc_p) duty_req <= duty_dn[DW-1:0];
    end
  end
endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed self-checking bench for pwm_gen
// Samples 1ns after each rising edge; inputs change at the same point.

module tb_pwm_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic increase_duty = 1'b0;
  logic decrease_duty = 1'b0;
  logic PWM_OUT;

  int total = 0;
  int bad = 0;

  pwm_gen dut (
    .clk           (clk),
    .reset         (reset),
    .increase_duty (increase_duty),
    .decrease_duty (decrease_duty),
    .PWM_OUT       (PWM_OUT)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  task automatic press_inc(input int hi, input int lo);
    increase_duty = 1'b1;
    tick(hi);
    increase_duty = 1'b0;
    tick(lo);
  endtask

  task automatic press_dec(input int hi, input int lo);
    decrease_duty = 1'b1;
    tick(hi);
    decrease_duty = 1'b0;
    tick(lo);
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (PWM_OUT === 1'b1) c++;
    end
  endtask

  int a, b, c;
  int exp_inc[6] = '{6, 7, 8, 9, 10, 10};
  int exp_dec[6] = '{4, 3, 2, 1, 0, 0};

  initial begin
    tick(2);

    // Reset state and default 1111100000 pattern
    reset = 1'b0;
    tick(1);
    chk("rst_pwm", int'(PWM_OUT), 0);
    chk("rst_cnt", int'(dut.cnt), 0);
    chk("rst_duty_act", int'(dut.duty_act), 5);
    chk("rst_duty_req", int'(dut.duty_req), 5);
    reset = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      tick(1);
      chk($sformatf("default_pat_%0d", j), int'(PWM_OUT), (((j - 1) % 10) < 5) ? 1 : 0);
    end

    // Increase to saturation
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press_inc(10, 10);
      chk($sformatf("inc_req_%0d", i), int'(dut.duty_req), exp_inc[i]);
      chk($sformatf("inc_act_%0d", i), int'(dut.duty_act), exp_inc[i]);
    end
    count_high(10, c);
    chk("inc_sat_highs", c, 10);

    // Decrease to floor, no wrap
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press_dec(10, 10);
      chk($sformatf("dec_req_%0d", i), int'(dut.duty_req), exp_dec[i]);
      chk($sformatf("dec_act_%0d", i), int'(dut.duty_act), exp_dec[i]);
    end
    count_high(10, c);
    chk("dec_floor_highs", c, 0);

    // Debounce: glitch ignored, short press and long hold give one step each
    do_reset();
    press_inc(3, 20);
    chk("glitch_req", int'(dut.duty_req), 5);
    press_inc(5, 20);
    chk("short_press_req", int'(dut.duty_req), 6);
    press_inc(40, 20);
    chk("long_hold_req", int'(dut.duty_req), 7);
    count_high(10, c);
    chk("long_hold_highs", c, 7);

    // Simultaneous presses cancel
    do_reset();
    increase_duty = 1'b1;
    decrease_duty = 1'b1;
    tick(10);
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    tick(20);
    chk("simul_req", int'(dut.duty_req), 5);
    chk("simul_act", int'(dut.duty_act), 5);

    // Mid-period change: duty_req moves at cnt=2, old duty finishes the period
    do_reset();
    tick(5);
    increase_duty = 1'b1;
    tick(7);
    chk("mid_req", int'(dut.duty_req), 6);
    chk("mid_cnt", int'(dut.cnt), 2);
    chk("mid_act_old", int'(dut.duty_act), 5);
    count_high(3, a);
    increase_duty = 1'b0;
    count_high(5, b);
    chk("mid_rest_highs", a + b, 3);
    chk("mid_act_new", int'(dut.duty_act), 6);
    count_high(10, c);
    chk("mid_next_highs", c, 6);

    // Reset asserted mid-period
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("midrst_cnt", int'(dut.cnt), 0);
    chk("midrst_act", int'(dut.duty_act), 5);
    chk("midrst_req", int'(dut.duty_req), 5);
    chk("midrst_pwm", int'(PWM_OUT), 0);
    reset = 1'b1;
    count_high(10, c);
    chk("midrst_highs", c, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
